// File: rtl/sample_ram_scheduler.sv
// Port-B scheduler for the shared data RAM: generates alternating EMG/ECG sample ticks,
// buffers each sample in a per-channel pending slot, and arbitrates RAM access with VGA reads.
module sample_ram_scheduler #(
    parameter int unsigned       ADDR_W          = 12,
    parameter int unsigned       DATA_W          = 32,
    parameter int unsigned       SAMPLE_INTERVAL = 125000,
    parameter int unsigned       DEPTH           = 640,
    parameter logic [ADDR_W-1:0] EMG_BASE        = ADDR_W'(12'h400),
    parameter logic [ADDR_W-1:0] ECG_BASE        = ADDR_W'(12'h680),
    parameter int unsigned       MAX_WAIT        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] emg_in,
    input  logic [DATA_W-1:0] ecg_in,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [9:0]        emg_index,
    output logic [9:0]        ecg_index,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam int unsigned   CW         = $clog2(SAMPLE_INTERVAL + 1);
    localparam int unsigned   WW         = $clog2(MAX_WAIT + 2);
    localparam logic [CW-1:0] TERMINAL   = CW'(SAMPLE_INTERVAL - 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);
    localparam logic [9:0]    LAST_IDX   = 10'(DEPTH - 1);

    typedef enum logic {CH_EMG = 1'b0, CH_ECG = 1'b1} ch_t;
    typedef enum logic [1:0] {G_IDLE, G_VGA, G_EMG, G_ECG} grant_t;

    // Channel arrays: element 0 is EMG, element 1 is ECG.
    logic [CW-1:0]             count;
    ch_t                       sel;
    logic [1:0]                pend;
    logic [1:0][DATA_W-1:0]    pdata;
    logic [1:0][ADDR_W-1:0]    paddr;
    logic [1:0][WW-1:0]        pwait;
    logic [1:0][9:0]           idx;

    logic                      terminal;
    logic [1:0]                tick;
    logic [1:0]                forced;
    logic [1:0]                issue;
    logic [1:0][DATA_W-1:0]    sample;
    logic [1:0][ADDR_W-1:0]    base;
    logic [1:0][9:0]           idx_next;
    grant_t                    grant;
    logic                      overrun_set;

    always_comb begin
        terminal  = (count == TERMINAL);
        tick[0]   = terminal && (sel == CH_EMG);
        tick[1]   = terminal && (sel == CH_ECG);
        sample[0] = emg_in;
        sample[1] = ecg_in;
        base[0]   = EMG_BASE;
        base[1]   = ECG_BASE;
        for (int unsigned i = 0; i < 2; i++) begin
            forced[i]   = pend[i] && (pwait[i] == WAIT_LIMIT);
            idx_next[i] = (idx[i] == LAST_IDX) ? '0 : idx[i] + 10'd1;
        end

        if (forced[0])      grant = G_EMG;
        else if (forced[1]) grant = G_ECG;
        else if (vga_req)   grant = G_VGA;
        else if (pend[0])   grant = G_EMG;
        else if (pend[1])   grant = G_ECG;
        else                grant = G_IDLE;

        issue[0]    = (grant == G_EMG);
        issue[1]    = (grant == G_ECG);
        overrun_set = |(tick & pend & ~issue);
    end

    // Port-B drive; held at zero while reset is asserted so nothing reaches the RAM.
    always_comb begin
        ram_wen  = 1'b0;
        ram_addr = vga_addr;
        ram_din  = '0;
        case (grant)
            G_EMG: begin
                ram_wen  = 1'b1;
                ram_addr = paddr[0];
                ram_din  = pdata[0];
            end
            G_ECG: begin
                ram_wen  = 1'b1;
                ram_addr = paddr[1];
                ram_din  = pdata[1];
            end
            default: ;
        endcase
        if (reset) begin
            ram_wen  = 1'b0;
            ram_addr = '0;
            ram_din  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            sel       <= CH_EMG;
            pend      <= '0;
            pdata     <= '0;
            paddr     <= '0;
            pwait     <= '0;
            idx       <= '0;
            vga_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            count <= terminal ? '0 : count + CW'(1);
            if (terminal) sel <= (sel == CH_EMG) ? CH_ECG : CH_EMG;

            for (int unsigned i = 0; i < 2; i++) begin
                if (issue[i]) idx[i] <= idx_next[i];

                if (issue[i] || !pend[i])       pwait[i] <= '0;
                else if (pwait[i] != WAIT_LIMIT) pwait[i] <= pwait[i] + WW'(1);

                // A tick on an unissued slot replaces only the data; its ring slot is kept.
                if (tick[i]) begin
                    pdata[i] <= sample[i];
                    pend[i]  <= 1'b1;
                    if (issue[i])     paddr[i] <= base[i] + ADDR_W'(idx_next[i]);
                    else if (!pend[i]) paddr[i] <= base[i] + ADDR_W'(idx[i]);
                end else if (issue[i]) begin
                    pend[i] <= 1'b0;
                end
            end

            vga_valid <= (grant == G_VGA);
            if (overrun_set)      overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

    assign vga_data  = ram_dout;
    assign emg_index = idx[0];
    assign ecg_index = idx[1];

endmodule
